// File: rtl/mpp_pkg.sv
// -----------------------------------------------------------------------------
// mpp_pkg
// Shared definitions for the mpp core and its program store: controller state
// encoding, default no-operation opcode, program address width and the index
// of the program-read strobe within the core's out_signals bus.
// -----------------------------------------------------------------------------
package mpp_pkg;

  localparam int         PROG_ADDR_W    = 16;    // core program address width
  localparam int         PROG_RD_BIT    = 1;     // out_signals bit driving prog_rd
  localparam logic [7:0] NOP_OPCODE_DEF = 8'h00; // opcode for empty / unmapped space

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // waiting for a read request or a loader session
    ST_WAIT = 2'd1,   // read accepted, counting wait states
    ST_LOAD = 2'd2    // loader session active
  } state_e;

endpackage : mpp_pkg

// File: rtl/mpp_prog_rom_if.sv
// -----------------------------------------------------------------------------
// mpp_prog_rom_if
// Bundles the program-read port (towards the mpp core) and the byte-stream
// loader port of mpp_prog_rom.
//   master : core / loader side (drives prog_rd, program_addr, load_*)
//   slave  : program store side (drives instruction, status and loader flow)
// -----------------------------------------------------------------------------
interface mpp_prog_rom_if #(
  parameter int ADDR_W = 8
);
  logic                            prog_rd;       // read strobe, level
  logic [mpp_pkg::PROG_ADDR_W-1:0] program_addr;  // read address
  logic [7:0]                      instruction;   // opcode to core
  logic                            instr_valid;   // one-cycle update pulse
  logic                            busy;          // read in wait states or loading
  logic                            load_en;       // loader session request
  logic                            load_valid;    // loader byte present
  logic [7:0]                      load_data;     // loader byte
  logic                            load_ready;    // byte can be accepted
  logic                            load_full;     // every location written
  logic [ADDR_W:0]                 load_count;    // bytes written this session

  modport master (
    output prog_rd, program_addr, load_en, load_valid, load_data,
    input  instruction, instr_valid, busy, load_ready, load_full, load_count
  );

  modport slave (
    input  prog_rd, program_addr, load_en, load_valid, load_data,
    output instruction, instr_valid, busy, load_ready, load_full, load_count
  );

endinterface : mpp_prog_rom_if

// File: rtl/mpp_prog_ram.sv
// -----------------------------------------------------------------------------
// mpp_prog_ram
// DEPTH x 8 program array with one write port and one registered read port.
// The read register only updates when i_re is high, so read data holds while
// the controller counts wait states.
// Ports:
//   clk      in  clock
//   i_we     in  write enable
//   i_waddr  in  write address
//   i_wdata  in  write data
//   i_re     in  read enable (captures mem[i_raddr] on the edge)
//   i_raddr  in  read address
//   o_rdata  out registered read data
// -----------------------------------------------------------------------------
module mpp_prog_ram #(
  parameter int         ADDR_W = 8,
  parameter logic [7:0] INIT   = 8'h00
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // NOTE: the array has no reset branch so it maps onto block RAM and keeps
  // its contents across a reset; only the power-up fill value is given.
  logic [7:0] r_mem [DEPTH] = '{default: INIT};
  logic [7:0] r_rdata       = INIT;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata        <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule : mpp_prog_ram

// File: rtl/mpp_prog_rom.sv
// -----------------------------------------------------------------------------
// mpp_prog_rom
// Program store in front of the mpp core. A rising edge on prog_rd requests
// the opcode at program_addr; it appears on instruction WAIT_STATES+1 clock
// edges later with a one-cycle instr_valid pulse. Addresses above the
// implemented range return NOP_OPCODE. While load_en is high the store is
// filled sequentially from address 0 through the byte-stream loader port.
// Ports:
//   clk  in  clock, all state on the rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave modport of mpp_prog_rom_if (read port + loader port)
// ADDR_W must be below 16 so that an out-of-range address field exists.
// -----------------------------------------------------------------------------
module mpp_prog_rom
  import mpp_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter int         WAIT_STATES = 1,
  parameter logic [7:0] NOP_OPCODE  = NOP_OPCODE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  mpp_prog_rom_if.slave        bus
);

  localparam int             DEPTH      = 2 ** ADDR_W;
  localparam logic [3:0]     WS         = 4'(WAIT_STATES);
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W + 1)'(DEPTH - 1);

  state_e          r_state;
  logic            r_prog_rd_q;
  logic [3:0]      r_wait_cnt;
  logic            r_oob;
  logic [7:0]      r_instruction;
  logic            r_instr_valid;
  logic            r_busy;
  logic            r_load_ready;
  logic            r_load_full;
  logic [ADDR_W:0] r_load_count;

  logic            w_rd_req;
  logic            w_rd_accept;
  logic            w_wr_en;
  logic            w_addr_oob;
  logic [7:0]      w_ram_q;

  assign w_rd_req    = bus.prog_rd & ~r_prog_rd_q;
  // A loader request in IDLE wins over a read request in the same cycle.
  assign w_rd_accept = (r_state == ST_IDLE) & ~bus.load_en & w_rd_req;
  // The exit cycle of a session (load_en low) never writes.
  assign w_wr_en     = (r_state == ST_LOAD) & bus.load_en & bus.load_valid & r_load_ready;
  assign w_addr_oob  = |bus.program_addr[PROG_ADDR_W-1:ADDR_W];

  // The write pointer is the low part of load_count: both start at 0 on
  // session entry and advance together, and writes stop once full.
  mpp_prog_ram #(
    .ADDR_W (ADDR_W),
    .INIT   (NOP_OPCODE)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_en),
    .i_waddr (r_load_count[ADDR_W-1:0]),
    .i_wdata (bus.load_data),
    .i_re    (w_rd_accept),
    .i_raddr (bus.program_addr[ADDR_W-1:0]),
    .o_rdata (w_ram_q)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_prog_rd_q   <= 1'b0;
      r_wait_cnt    <= 4'd0;
      r_oob         <= 1'b0;
      r_instruction <= NOP_OPCODE;
      r_instr_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_load_ready  <= 1'b0;
      r_load_full   <= 1'b0;
      r_load_count  <= '0;
    end else begin
      r_prog_rd_q   <= bus.prog_rd;
      r_instr_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.load_en) begin
            r_state      <= ST_LOAD;
            r_load_count <= '0;
            r_load_full  <= 1'b0;
            r_load_ready <= 1'b1;
            r_busy       <= 1'b1;
          end else if (w_rd_req) begin
            // With zero wait states WAIT lasts a single cycle and the read
            // is not reported as busy.
            r_state    <= ST_WAIT;
            r_oob      <= w_addr_oob;
            r_wait_cnt <= WS;
            r_busy     <= (WS != 4'd0);
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_instruction <= r_oob ? NOP_OPCODE : w_ram_q;
            r_instr_valid <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ST_LOAD: begin
          if (!bus.load_en) begin
            r_state      <= ST_IDLE;
            r_load_ready <= 1'b0;
            r_busy       <= 1'b0;
          end else if (w_wr_en) begin
            r_load_count <= r_load_count + 1'b1;
            if (r_load_count == LAST_COUNT) begin
              r_load_full  <= 1'b1;
              r_load_ready <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.instruction = r_instruction;
  assign bus.instr_valid = r_instr_valid;
  assign bus.busy        = r_busy;
  assign bus.load_ready  = r_load_ready;
  assign bus.load_full   = r_load_full;
  assign bus.load_count  = r_load_count;

endmodule : mpp_prog_rom

// File: tb/tb_mpp_prog_rom.sv
// -----------------------------------------------------------------------------
// tb_mpp_prog_rom
// Self-checking bench for mpp_prog_rom (ADDR_W=8, WAIT_STATES=1). A byte-array
// model of the program store tracks every loader session; reads are checked
// for data, latency, instr_valid pulse and busy.
// -----------------------------------------------------------------------------
module tb_mpp_prog_rom;

  localparam int ADDR_W = 8;
  localparam int WS     = 1;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mpp_prog_rom_if #(.ADDR_W(ADDR_W)) bus ();

  mpp_prog_rom #(
    .ADDR_W      (ADDR_W),
    .WAIT_STATES (WS),
    .NOP_OPCODE  (8'h00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  logic [7:0] ref_mem [DEPTH];
  int         ref_count;
  logic [7:0] ref_instr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_read(input logic [15:0] addr);
    if (addr >= 16'(DEPTH)) return 8'h00;
    return ref_mem[addr];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One read: rising edge on prog_rd, result WS+1 edges after the sampling edge.
  task automatic do_read(input logic [15:0] addr);
    logic [7:0] exp;
    exp = ref_read(addr);
    bus.program_addr = addr;
    bus.prog_rd      = 1'b1;
    step();
    check("rd_busy", bus.busy, 1'b1);
    for (int k = 1; k <= WS + 1; k++) begin
      step();
      if (k == WS + 1) ref_instr = exp;
      check("rd_valid", bus.instr_valid, (k == WS + 1));
      check("rd_instr", bus.instruction, ref_instr);
    end
    check("rd_busy_done", bus.busy, 1'b0);
    bus.prog_rd = 1'b0;
    step();
    check("rd_valid_drop", bus.instr_valid, 1'b0);
  endtask

  // Loader session; gaps inserts random idle cycles. The exit cycle offers
  // a byte which must not be written.
  task automatic load_session(input logic [7:0] data [$], input bit gaps);
    int i;
    int cyc;
    bus.load_en = 1'b1;
    step();
    ref_count = 0;
    check("ld_entry_busy", bus.busy, 1'b1);
    check("ld_entry_ready", bus.load_ready, 1'b1);
    check("ld_entry_count", bus.load_count, 0);
    check("ld_entry_full", bus.load_full, 1'b0);
    i   = 0;
    cyc = 0;
    while (i < data.size() && cyc < 4000) begin
      bus.load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.load_data  = data[i];
      step();
      cyc++;
      if (bus.load_valid) begin
        if (ref_count < DEPTH) begin
          ref_mem[ref_count] = data[i];
          ref_count++;
        end
        i++;
        check("ld_count", bus.load_count, ref_count);
        check("ld_full", bus.load_full, (ref_count == DEPTH));
        check("ld_ready", bus.load_ready, (ref_count != DEPTH));
      end
    end
    if (i < data.size()) check("ld_timeout", i, data.size());
    bus.load_en    = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    step();
    bus.load_valid = 1'b0;
    check("ld_exit_busy", bus.busy, 1'b0);
    check("ld_exit_ready", bus.load_ready, 1'b0);
    check("ld_exit_count", bus.load_count, ref_count);
  endtask

  initial begin
    logic [7:0] q [$];
    int         pulses;
    logic [15:0] a;

    for (int j = 0; j < DEPTH; j++) ref_mem[j] = 8'h00;
    ref_count = 0;
    ref_instr = 8'h00;
    bus.prog_rd      = 1'b0;
    bus.program_addr = '0;
    bus.load_en      = 1'b0;
    bus.load_valid   = 1'b0;
    bus.load_data    = '0;

    step();
    step();
    rst = 1'b0;
    step();
    check("rst_instr", bus.instruction, 8'h00);
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ready", bus.load_ready, 1'b0);
    check("rst_full", bus.load_full, 1'b0);
    check("rst_count", bus.load_count, 0);

    // Directed program and reads, including one past the loaded bytes.
    q = '{8'h07, 8'hC0, 8'h44, 8'hC1, 8'hCB};
    load_session(q, 1'b0);
    for (int j = 0; j <= 5; j++) do_read(16'(j));

    // prog_rd held high: only one read.
    bus.program_addr = 16'h0002;
    bus.prog_rd      = 1'b1;
    pulses = 0;
    for (int j = 0; j < 5; j++) begin
      step();
      if (bus.instr_valid) pulses++;
    end
    bus.prog_rd = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      if (bus.instr_valid) pulses++;
    end
    ref_instr = ref_read(16'h0002);
    check("hold_pulses", pulses, 1);
    check("hold_instr", bus.instruction, ref_instr);

    // Out-of-range address.
    do_read(16'h0100);

    // Read request during LOAD is ignored.
    do_read(16'h0003);
    bus.load_en = 1'b1;
    step();
    ref_count = 0;
    bus.program_addr = 16'h0000;
    bus.prog_rd      = 1'b1;
    for (int j = 0; j < 4; j++) begin
      step();
      check("load_rd_valid", bus.instr_valid, 1'b0);
      check("load_rd_instr", bus.instruction, ref_instr);
    end
    bus.prog_rd = 1'b0;
    bus.load_en = 1'b0;
    step();
    check("load_rd_count", bus.load_count, 0);

    // load_en during WAIT does not abort the read; LOAD follows.
    bus.program_addr = 16'h0001;
    bus.prog_rd      = 1'b1;
    step();
    bus.load_en = 1'b1;
    step();
    check("wait_ld_valid0", bus.instr_valid, 1'b0);
    step();
    ref_instr = ref_read(16'h0001);
    check("wait_ld_valid1", bus.instr_valid, 1'b1);
    check("wait_ld_instr", bus.instruction, ref_instr);
    step();
    check("wait_ld_busy", bus.busy, 1'b1);
    check("wait_ld_ready", bus.load_ready, 1'b1);
    bus.prog_rd = 1'b0;
    bus.load_en = 1'b0;
    step();
    ref_count = 0;

    // Random session with gaps, then random reads over the whole range.
    q = {};
    for (int j = 0; j < 40; j++) q.push_back(8'($urandom));
    load_session(q, 1'b1);
    for (int j = 0; j < 24; j++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 48));
      do_read(a);
    end

    // Overfill: 257 bytes into 256 locations.
    q = {};
    for (int j = 0; j < DEPTH + 1; j++) q.push_back(8'($urandom));
    load_session(q, 1'b0);
    check("full_flag", bus.load_full, 1'b1);
    do_read(16'h0000);
    do_read(16'h00FF);
    for (int j = 0; j < 8; j++) do_read(16'($urandom_range(0, 255)));

    // Reset in the middle of a wait state.
    bus.program_addr = 16'h00FF;
    bus.prog_rd      = 1'b1;
    step();
    rst = 1'b1;
    #1;
    ref_instr = 8'h00;
    ref_count = 0;
    check("rst_mid_instr", bus.instruction, 8'h00);
    check("rst_mid_valid", bus.instr_valid, 1'b0);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_count", bus.load_count, 0);
    bus.prog_rd = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("rst_mid_after", bus.instr_valid, 1'b0);
    do_read(16'h0000);
    do_read(16'h0080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench did not complete");
  end

endmodule : tb_mpp_prog_rom
